// File: rtl/pipelined_adder_n_pkg.sv
// Shared sizing helpers for the pipelined slice adder/subtractor.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package pipelined_adder_n_pkg;

    // Number of operand bits handled by each pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // True when the width splits into whole, non-empty slices.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_n_slice.sv
// One SLICE-bit ripple adder: a + b + cin -> sum, carry out, carry into the slice MSB.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline gates its registers.
module adder_slice
    import pipelined_adder_n_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    logic [W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by xor.
    assign o_cmsb = w_full[W-1] ^ i_a[W-1] ^ i_b[W-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor, one SLICE-bit slice per stage, carry registered between stages.
// Latency: STAGES cycles from acceptance to out_valid; one transaction per cycle.
// Backpressure: single global enable (!out_valid || out_ready) freezes every stage, bubbles included.
module pipelined_adder_n
    import pipelined_adder_n_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder_n: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic w_adv;

    // The output register is the only place a stall originates, so one enable drives every stage.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * SLICE;      // sum bits already produced upstream
        localparam int REM = WIDTH - LO;     // operand bits not yet consumed

        logic                w_vld_in;
        logic                w_cin;
        logic [REM-1:0]      w_a_in;
        logic [REM-1:0]      w_b_in;
        logic [SLICE-1:0]    w_s;
        logic                w_co;
        logic                w_cmsb;
        logic [LO+SLICE-1:0] w_sum_nxt;

        logic                r_vld;
        logic                r_cy;
        logic [LO+SLICE-1:0] r_sum;

        // Subtraction is folded in at entry: B is inverted once and the +1 rides in as carry-in,
        // so later stages never need to know the mode.
        if (k == 0) begin : g_src
            assign w_vld_in  = in_valid;
            assign w_cin     = in_sub;
            assign w_a_in    = in_a;
            assign w_b_in    = in_b ^ {WIDTH{in_sub}};
            assign w_sum_nxt = w_s;
        end else begin : g_src
            assign w_vld_in  = g_stg[k-1].r_vld;
            assign w_cin     = g_stg[k-1].r_cy;
            assign w_a_in    = g_stg[k-1].g_mid.r_a;
            assign w_b_in    = g_stg[k-1].g_mid.r_b;
            assign w_sum_nxt = {w_s, g_stg[k-1].r_sum};
        end

        adder_slice #(
            .W      (SLICE)
        ) u_slice (
            .i_a    (w_a_in[SLICE-1:0]),
            .i_b    (w_b_in[SLICE-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_s),
            .o_cout (w_co),
            .o_cmsb (w_cmsb)
        );

        // Stage valid, slice carry and accumulated low sum bits advance together.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                r_cy  <= w_co;
                r_sum <= w_sum_nxt;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            // Signed overflow: carry into the top bit disagrees with carry out of it.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_cmsb ^ w_co;
                end
            end
        end else begin : g_mid
            logic [REM-SLICE-1:0] r_a;
            logic [REM-SLICE-1:0] r_b;
            logic                 w_unused_cmsb;

            // Only the final slice's MSB carry matters for overflow.
            assign w_unused_cmsb = w_cmsb;

            // Forward just the operand slices still waiting to be added.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in[REM-1:SLICE];
                    r_b <= w_b_in[REM-1:SLICE];
                end
            end
        end
    end

    assign out_valid    = g_stg[STAGES-1].r_vld;
    assign out_sum      = g_stg[STAGES-1].r_sum;
    assign out_carry    = g_stg[STAGES-1].r_cy;
    assign out_overflow = g_stg[STAGES-1].g_last.r_ovf;

endmodule
